// File: rtl/id_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, instruction classes,
// SYSTEM funct12 values and the ID/EX register layout.
package id_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;

    // SYSTEM funct12 encodings (inst[31:20])
    localparam logic [11:0] F12_ECALL = 12'h000;
    localparam logic [11:0] F12_MRET  = 12'h302;

    // Instruction class; OP_NOP is zero so a cleared ID/EX register reads as a bubble
    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LUI   = 4'd1,
        OP_AUIPC = 4'd2,
        OP_JAL   = 4'd3,
        OP_JALR  = 4'd4,
        OP_BR    = 4'd5,
        OP_LD    = 4'd6,
        OP_ST    = 4'd7,
        OP_OPIMM = 4'd8,
        OP_OP    = 4'd9,
        OP_FENCE = 4'd10,
        OP_SYS   = 4'd11
    } opcls_e;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1_adr;
        logic [4:0]  rs2_adr;
        logic [4:0]  rd_adr;
        logic [31:0] imm;
        logic [3:0]  opcls;
        logic [2:0]  funct3;
        logic        f7b5;
        logic        wbk_en;
        logic        ld;
        logic        st;
        logic        ecall;
        logic        mret;
        logic        illegal;
    } idex_t;

    // Classes that read rs1 as an operand
    function automatic logic uses_rs1(input logic [3:0] cls);
        return !(cls inside {OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE, OP_NOP});
    endfunction

    // Classes that read rs2 as an operand
    function automatic logic uses_rs2(input logic [3:0] cls);
        return cls inside {OP_BR, OP_ST, OP_OP};
    endfunction

endpackage

// File: rtl/id_stage_rf_2r1w.sv
// Integer register file: 31 writable 32-bit registers, x0 hard-wired to zero,
// two combinational read ports with write-through bypass, one write port.
module rf_2r1w (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic        we
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [4:0]  ra     [2];
    logic [31:0] rdata  [2];

    assign ra[0] = ra1;
    assign ra[1] = ra2;
    assign rd1   = rdata[0];
    assign rd2   = rdata[1];

    // Read ports: x0 is always zero, a same-cycle write to the read address is forwarded
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign rdata[gi] = (ra[gi] == 5'd0)           ? 32'd0 :
                               (we && (wa == ra[gi]))     ? wd    :
                                                            regs_q[ra[gi]];
        end
    endgenerate

    // Next register contents: writes to x0 are dropped so entry 0 stays zero
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
    end

    // Register storage; reset clears everything and wins over a pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes inst_id, reads the register file, builds the
// immediate and control flags, detects load-use hazards and registers the
// result into the ID/EX pipeline register.
module id_stage
    import id_pkg::*;
#(
    parameter logic [29:0] RESET_PC = 30'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_id,
    input  logic [29:0] pc_id,
    input  logic        stall,
    input  logic        rst_pipe,
    input  logic [4:0]  wbk_rd_reg,
    input  logic [31:0] wbk_data,
    input  logic        wbk_wen,
    output logic        stall_ld,
    output logic [29:0] pc_ex,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex,
    output logic [4:0]  rs1_adr_ex,
    output logic [4:0]  rs2_adr_ex,
    output logic [4:0]  rd_adr_ex,
    output logic [31:0] imm_ex,
    output logic [3:0]  opcls_ex,
    output logic [2:0]  funct3_ex,
    output logic        f7b5_ex,
    output logic        wbk_en_ex,
    output logic        ld_ex,
    output logic        st_ex,
    output logic        ecall_ex,
    output logic        mret_ex,
    output logic        illegal_ex
);

    logic [6:0]  opcode;
    logic [4:0]  rs1_adr;
    logic [4:0]  rs2_adr;
    logic [4:0]  rd_adr;
    logic [2:0]  funct3;
    logic [11:0] funct12;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    opcls_e      cls;
    logic        is_ecall;
    logic        is_mret;
    logic        is_illegal;
    logic        wbk_en;
    logic [31:0] imm;
    idex_t       dec;
    idex_t       bubble;
    idex_t       idex_d;
    idex_t       idex_q;

    assign opcode  = inst_id[6:0];
    assign rd_adr  = inst_id[11:7];
    assign funct3  = inst_id[14:12];
    assign rs1_adr = inst_id[19:15];
    assign rs2_adr = inst_id[24:20];
    assign funct12 = inst_id[31:20];

    rf_2r1w u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_adr),
        .ra2 (rs2_adr),
        .rd1 (rs1_rdata),
        .rd2 (rs2_rdata),
        .wa  (wbk_rd_reg),
        .wd  (wbk_data),
        .we  (wbk_wen)
    );

    // Opcode to class; unknown opcodes become an illegal NOP-class slot
    always_comb begin
        cls        = OP_NOP;
        is_ecall   = 1'b0;
        is_mret    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OPC_LUI:   cls = OP_LUI;
            OPC_AUIPC: cls = OP_AUIPC;
            OPC_JAL:   cls = OP_JAL;
            OPC_JALR:  cls = OP_JALR;
            OPC_BR:    cls = OP_BR;
            OPC_LD:    cls = OP_LD;
            OPC_ST:    cls = OP_ST;
            OPC_OPIMM: cls = OP_OPIMM;
            OPC_OP:    cls = OP_OP;
            OPC_FENCE: cls = OP_FENCE;
            OPC_SYS: begin
                cls = OP_SYS;
                if ((funct3 == 3'd0) && (funct12 == F12_ECALL)) begin
                    is_ecall = 1'b1;
                end else if ((funct3 == 3'd0) && (funct12 == F12_MRET)) begin
                    is_mret = 1'b1;
                end else begin
                    is_illegal = 1'b1;
                end
            end
            default:   is_illegal = 1'b1;
        endcase
    end

    // Immediate generation by format; R-type and illegal slots carry zero
    always_comb begin
        case (cls)
            OP_LUI, OP_AUIPC:
                imm = {inst_id[31:12], 12'd0};
            OP_JAL:
                imm = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12],
                       inst_id[20], inst_id[30:21], 1'b0};
            OP_BR:
                imm = {{19{inst_id[31]}}, inst_id[31], inst_id[7],
                       inst_id[30:25], inst_id[11:8], 1'b0};
            OP_ST:
                imm = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
            OP_JALR, OP_LD, OP_OPIMM, OP_FENCE, OP_SYS:
                imm = {{20{inst_id[31]}}, inst_id[31:20]};
            default:
                imm = 32'd0;
        endcase
    end

    // Register write-back only for classes that produce a result, never to x0
    always_comb begin
        wbk_en = 1'b0;
        if (cls inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_OPIMM, OP_OP}) begin
            wbk_en = (rd_adr != 5'd0);
        end
    end

    // Load-use hazard against the load sitting in EX; a flush makes it moot
    assign stall_ld = idex_q.ld && (idex_q.rd_adr != 5'd0) && !rst_pipe &&
                      ((uses_rs1(cls) && (rs1_adr == idex_q.rd_adr)) ||
                       (uses_rs2(cls) && (rs2_adr == idex_q.rd_adr)));

    // Assemble the decoded and bubble forms of the ID/EX contents
    always_comb begin
        dec          = '0;
        dec.pc       = pc_id;
        dec.rs1_data = rs1_rdata;
        dec.rs2_data = rs2_rdata;
        dec.rs1_adr  = rs1_adr;
        dec.rs2_adr  = rs2_adr;
        dec.rd_adr   = rd_adr;
        dec.imm      = imm;
        dec.opcls    = cls;
        dec.funct3   = funct3;
        dec.f7b5     = inst_id[30];
        dec.wbk_en   = wbk_en;
        dec.ld       = (cls == OP_LD);
        dec.st       = (cls == OP_ST);
        dec.ecall    = is_ecall;
        dec.mret     = is_mret;
        dec.illegal  = is_illegal;

        bubble       = '0;
        bubble.pc    = RESET_PC;
        bubble.opcls = OP_NOP;
    end

    // ID/EX next state: flush, then hold on stall, then hazard bubble, else advance
    always_comb begin
        if (rst_pipe) begin
            idex_d = bubble;
        end else if (stall) begin
            idex_d = idex_q;
        end else if (stall_ld) begin
            idex_d = bubble;
        end else begin
            idex_d = dec;
        end
    end

    // ID/EX pipeline register; reset value equals a bubble at RESET_PC
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= bubble;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign pc_ex       = idex_q.pc;
    assign rs1_data_ex = idex_q.rs1_data;
    assign rs2_data_ex = idex_q.rs2_data;
    assign rs1_adr_ex  = idex_q.rs1_adr;
    assign rs2_adr_ex  = idex_q.rs2_adr;
    assign rd_adr_ex   = idex_q.rd_adr;
    assign imm_ex      = idex_q.imm;
    assign opcls_ex    = idex_q.opcls;
    assign funct3_ex   = idex_q.funct3;
    assign f7b5_ex     = idex_q.f7b5;
    assign wbk_en_ex   = idex_q.wbk_en;
    assign ld_ex       = idex_q.ld;
    assign st_ex       = idex_q.st;
    assign ecall_ex    = idex_q.ecall;
    assign mret_ex     = idex_q.mret;
    assign illegal_ex  = idex_q.illegal;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction decode stage. Sits directly downstream of the instruction fetch stage.
- Takes the fetched instruction and PC, reads the integer register file, and builds the sign-extended immediate and control flags.
- Registers all results into the ID/EX pipeline register.
- Detects load-use hazards and drives stall_ld back to fetch. Accepts the write-back port from the WB stage.

Parameters:
- RESET_PC, 30'd0, value loaded into pc_ex on reset and on bubble insertion.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- inst_id  in  32  instruction from fetch
- pc_id  in  30  [31:2] PC of inst_id
- stall  in  1  global stall; hold ID/EX register
- rst_pipe  in  1  flush (jump/trap taken in EX)
- wbk_rd_reg  in  5  write-back destination
- wbk_data  in  32  write-back data
- wbk_wen  in  1  write-back enable
- stall_ld  out  1  load-use hazard; to fetch
- pc_ex  out  30  registered PC
- rs1_data_ex, rs2_data_ex  out  32 each  operand values
- rs1_adr_ex, rs2_adr_ex, rd_adr_ex  out  5 each  register indices, for forwarding
- imm_ex  out  32  sign-extended immediate
- opcls_ex  out  4  instruction class (id_pkg enum)
- funct3_ex  out  3  funct3 field
- f7b5_ex  out  1  inst[30]
- wbk_en_ex  out  1  instruction writes rd (rd != 0)
- ld_ex  out  1  load
- st_ex  out  1  store
- ecall_ex  out  1  ecall
- mret_ex  out  1  mret
- illegal_ex  out  1  undecodable opcode

Behaviour:
- Reset (rst=1 at a clk edge):
  - All *_ex flags = 0; data outputs = 0; pc_ex = RESET_PC.
  - Register file x1..x31 = 0.
  - stall_ld = 0 during the following cycle.
- Latency:
  - Decode and register read are combinational from inst_id/pc_id.
  - Results are captured into ID/EX at the next clk edge: 1-cycle latency.
- ID/EX update priority per edge, highest first:
  1. rst: reset values.
  2. rst_pipe: bubble.
  3. stall: hold all ID/EX regs.
  4. stall_ld: bubble.
  5. Otherwise: load the decoded values.
- Bubble definition:
  - wbk_en_ex, ld_ex, st_ex, ecall_ex, mret_ex, illegal_ex = 0.
  - opcls_ex = OP_NOP; imm_ex and data outputs = 0.
- Immediates, sign-extended from inst[31]:
  - I, S, B, U, J formats per RV32I.
  - B and J have bit 0 forced to 0. U has imm[11:0] = 0.
- Opcode classes: LUI, AUIPC, JAL, JALR, BR, LD, ST, OPIMM, OP, FENCE, SYS, NOP.
  - Any other inst[6:0] -> illegal_ex=1, wbk_en_ex=0.
- SYS class:
  - funct3=0 and inst[31:20]=0x000 -> ecall_ex.
  - funct3=0 and inst[31:20]=0x302 -> mret_ex.
  - Other SYS encodings -> illegal_ex.
- wbk_en_ex = 1 for LUI, AUIPC, JAL, JALR, LD, OPIMM, OP, and only when rd != 0.
- Register file:
  - 31x32 flops; x0 reads 0; writes to x0 are ignored.
  - Write occurs at the clk edge when wbk_wen=1, including during stall and stall_ld.
  - Same-cycle read of the address being written returns wbk_data (write-through bypass), except for x0.
- stall_ld (combinational), asserted when all of the following hold:
  - ld_ex = 1 and rd_adr_ex != 0;
  - (rs1 used and rs1 == rd_adr_ex) or (rs2 used and rs2 == rd_adr_ex).
  - rs1 is used by all classes except LUI, AUIPC, JAL, FENCE, NOP.
  - rs2 is used only by BR, ST, OP.
- stall_ld duration: the inserted bubble clears ld_ex, so stall_ld lasts exactly 1 cycle. Fetch replays the same inst_id in the next cycle.
- stall_ld is forced to 0 while rst_pipe=1.
- Simultaneous stall and stall_ld: stall wins (hold). stall_ld remains asserted while the condition persists.
- Reset mid-operation: in-flight ID/EX contents are discarded; no write-back is committed on a reset edge.

Decomposition:
- Package id_pkg: opcode constants (7-bit), opcls enum (4-bit), OP_NOP, SYS funct12 values (ECALL 12'h000, MRET 12'h302).
- One sub-module: rf_2r1w (register file with x0 handling and write-through bypass).
- Decoder, immediate generation, hazard logic and ID/EX register stay in id_stage.

Test Plan:
- ADDI x1,x0,5 (0x00500093), pc_id=0x10 -> next cycle: opcls_ex=OPIMM, imm_ex=5, rd_adr_ex=1, wbk_en_ex=1, rs1_data_ex=0, pc_ex=0x10.
- BEQ x0,x0,-4 (0xFE000EE3) -> imm_ex=0xFFFFFFFC, opcls_ex=BR, wbk_en_ex=0.
- LW x2,0(x1) (0x0000A103) then ADD x3,x2,x2 (0x002101B3):
  - stall_ld=1 for exactly 1 cycle; bubble enters EX.
  - ADD then issues with rs1_adr_ex=rs2_adr_ex=2.
- Write x5=0xDEADBEEF (wbk_wen=1) in the same cycle inst_id reads x5 as rs1 -> rs1_data_ex=0xDEADBEEF.
  - A write to x0 of 0x1234 followed by a read of x0 -> 0.
- ADDI in ID with rst_pipe=1 -> next cycle a bubble (all flags 0); with stall=1 instead -> ID/EX values unchanged.
- Unknown opcode 0x0000007F -> illegal_ex=1, wbk_en_ex=0.
  - ECALL 0x00000073 -> ecall_ex=1.
  - MRET 0x30200073 -> mret_ex=1.
